// File: rtl/tcdm_wide_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tcdm_wide_rr_arbiter
//  Brief    : Round-robin arbiter sharing one wide TCDM master port between
//             NB_REQ wide requesters. Grant IDs are queued in an in-order FIFO
//             so that each response is routed back to the requester that
//             issued the matching transaction.
//  Revision : 1.0 - initial release
// ============================================================================
module tcdm_wide_rr_arbiter #(
  parameter int NB_REQ          = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int WIDE_WIDTH      = 128,
  parameter int BE_WIDTH        = WIDE_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  // requester side
  input  logic [NB_REQ-1:0]                    data_req_slave,
  input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]    data_add_slave,
  input  logic [NB_REQ-1:0]                    data_wen_slave,
  input  logic [NB_REQ-1:0][WIDE_WIDTH-1:0]    data_wdata_slave,
  input  logic [NB_REQ-1:0][BE_WIDTH-1:0]      data_be_slave,
  output logic [NB_REQ-1:0]                    data_gnt_slave,
  output logic [NB_REQ-1:0]                    data_r_valid_slave,
  output logic [NB_REQ-1:0][WIDE_WIDTH-1:0]    data_r_rdata_slave,
  // shared TCDM side
  output logic                                 data_req_master,
  output logic [ADDR_WIDTH-1:0]                data_add_master,
  output logic                                 data_wen_master,
  output logic [WIDE_WIDTH-1:0]                data_wdata_master,
  output logic [BE_WIDTH-1:0]                  data_be_master,
  input  logic                                 data_gnt_master,
  input  logic                                 data_r_valid_master,
  input  logic [WIDE_WIDTH-1:0]                data_r_rdata_master,
  // status
  output logic                                 arb_err_o
);

  // Requester-ID width, FIFO pointer width and occupancy counter width.
  localparam int c_id_w  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int c_fp_w  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int c_cnt_w = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [c_id_w:0]    c_nb_req_ext = (c_id_w + 1)'(NB_REQ);
  localparam logic [c_id_w-1:0]  c_last_id    = c_id_w'(NB_REQ - 1);
  localparam logic [c_fp_w-1:0]  c_last_slot  = c_fp_w'(MAX_OUTSTANDING - 1);
  localparam logic [c_cnt_w-1:0] c_max_cnt    = c_cnt_w'(MAX_OUTSTANDING);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_id_w-1:0]  r_rr_ptr;
  logic [c_id_w-1:0]  r_id_fifo [MAX_OUTSTANDING];
  logic [c_fp_w-1:0]  r_wr_ptr;
  logic [c_fp_w-1:0]  r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_arb_err;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [2*NB_REQ-1:0] w_req_dbl;
  logic [NB_REQ-1:0]   w_req_rot;
  logic [c_id_w-1:0]   w_off;
  logic [c_id_w:0]     w_sum;
  logic [c_id_w-1:0]   w_winner;
  logic [c_id_w-1:0]   w_rr_next;
  logic                w_any_req;
  logic                w_full;
  logic                w_empty;
  logic                w_req_master;
  logic                w_push;
  logic                w_pop;
  logic                w_stray_rsp;
  logic [c_id_w-1:0]   w_head_id;

  // Rotate the request vector so that bit 0 corresponds to rr_ptr; the
  // lowest set bit of the rotated vector is then the round-robin winner.
  assign w_req_dbl = {data_req_slave, data_req_slave} >> r_rr_ptr;
  assign w_req_rot = w_req_dbl[NB_REQ-1:0];
  assign w_any_req = |data_req_slave;

  // Priority-encode the rotated requests: smallest offset from rr_ptr wins.
  always_comb begin
    w_off = '0;
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_off = c_id_w'(i);
      end
    end
  end

  // Map the offset back to an absolute requester index (mod NB_REQ, which
  // need not be a power of two).
  assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_winner = (w_sum >= c_nb_req_ext) ? c_id_w'(w_sum - c_nb_req_ext)
                                            : w_sum[c_id_w-1:0];
  assign w_rr_next = (w_winner == c_last_id) ? '0 : w_winner + 1'b1;

  // FIFO status and handshakes. Reset masks everything so that no transaction
  // is issued or retired while the arbiter is being cleared.
  assign w_full       = (r_count == c_max_cnt);
  assign w_empty      = (r_count == '0);
  assign w_req_master = w_any_req & ~w_full & ~rst;
  assign w_push       = w_req_master & data_gnt_master;
  assign w_pop        = data_r_valid_master & ~w_empty & ~rst;
  assign w_stray_rsp  = data_r_valid_master & w_empty & ~rst;
  assign w_head_id    = r_id_fifo[r_rd_ptr];

  // Forward the winner's request fields; idle port is driven to zero.
  always_comb begin
    data_req_master   = w_req_master;
    data_add_master   = '0;
    data_wen_master   = 1'b0;
    data_wdata_master = '0;
    data_be_master    = '0;
    if (w_req_master) begin
      data_add_master   = data_add_slave[w_winner];
      data_wen_master   = data_wen_slave[w_winner];
      data_wdata_master = data_wdata_slave[w_winner];
      data_be_master    = data_be_slave[w_winner];
    end
  end

  // Only the current winner sees the grant, and only on a real handshake.
  always_comb begin
    data_gnt_slave = '0;
    if (w_push) begin
      data_gnt_slave[w_winner] = 1'b1;
    end
  end

  // Route a response to the requester at the head of the ID FIFO.
  always_comb begin
    data_r_valid_slave = '0;
    data_r_rdata_slave = '0;
    if (w_pop) begin
      data_r_valid_slave[w_head_id] = 1'b1;
      data_r_rdata_slave[w_head_id] = data_r_rdata_master;
    end
  end

  assign arb_err_o = r_arb_err;

  // Round-robin pointer advances past the winner on every handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_push) begin
      r_rr_ptr <= w_rr_next;
    end
  end

  // ID FIFO storage; contents are don't-care while the count is zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_id_fifo[r_wr_ptr] <= w_winner;
    end
  end

  // ID FIFO pointers and occupancy; simultaneous push/pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_last_slot) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last_slot) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error: a response arrived with nothing outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arb_err <= 1'b0;
    end else if (w_stray_rsp) begin
      r_arb_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tcdm_wide_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tcdm_wide_rr_arbiter
//  Brief    : Directed self-checking bench for tcdm_wide_rr_arbiter
//             (NB_REQ=2, WIDE_WIDTH=128, MAX_OUTSTANDING=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tcdm_wide_rr_arbiter;

  localparam int NB_REQ          = 2;
  localparam int ADDR_WIDTH      = 32;
  localparam int WIDE_WIDTH      = 128;
  localparam int BE_WIDTH        = WIDE_WIDTH / 8;
  localparam int MAX_OUTSTANDING = 4;

  logic                              clk;
  logic                              rst;
  logic [NB_REQ-1:0]                 data_req_slave;
  logic [NB_REQ-1:0][ADDR_WIDTH-1:0] data_add_slave;
  logic [NB_REQ-1:0]                 data_wen_slave;
  logic [NB_REQ-1:0][WIDE_WIDTH-1:0] data_wdata_slave;
  logic [NB_REQ-1:0][BE_WIDTH-1:0]   data_be_slave;
  logic [NB_REQ-1:0]                 data_gnt_slave;
  logic [NB_REQ-1:0]                 data_r_valid_slave;
  logic [NB_REQ-1:0][WIDE_WIDTH-1:0] data_r_rdata_slave;
  logic                              data_req_master;
  logic [ADDR_WIDTH-1:0]             data_add_master;
  logic                              data_wen_master;
  logic [WIDE_WIDTH-1:0]             data_wdata_master;
  logic [BE_WIDTH-1:0]               data_be_master;
  logic                              data_gnt_master;
  logic                              data_r_valid_master;
  logic [WIDE_WIDTH-1:0]             data_r_rdata_master;
  logic                              arb_err_o;

  int n_checks = 0;
  int n_pass   = 0;

  tcdm_wide_rr_arbiter #(
    .NB_REQ          (NB_REQ),
    .ADDR_WIDTH      (ADDR_WIDTH),
    .WIDE_WIDTH      (WIDE_WIDTH),
    .BE_WIDTH        (BE_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .data_req_slave      (data_req_slave),
    .data_add_slave      (data_add_slave),
    .data_wen_slave      (data_wen_slave),
    .data_wdata_slave    (data_wdata_slave),
    .data_be_slave       (data_be_slave),
    .data_gnt_slave      (data_gnt_slave),
    .data_r_valid_slave  (data_r_valid_slave),
    .data_r_rdata_slave  (data_r_rdata_slave),
    .data_req_master     (data_req_master),
    .data_add_master     (data_add_master),
    .data_wen_master     (data_wen_master),
    .data_wdata_master   (data_wdata_master),
    .data_be_master      (data_be_master),
    .data_gnt_master     (data_gnt_master),
    .data_r_valid_master (data_r_valid_master),
    .data_r_rdata_master (data_r_rdata_master),
    .arb_err_o           (arb_err_o)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net against a stuck run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] C_A5   = {16{8'hA5}};
  localparam logic [127:0] C_WD0  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

  initial begin
    rst                 = 1'b1;
    data_req_slave      = '0;
    data_add_slave      = '0;
    data_wen_slave      = '0;
    data_wdata_slave    = '0;
    data_be_slave       = '0;
    data_gnt_master     = 1'b0;
    data_r_valid_master = 1'b0;
    data_r_rdata_master = '0;
    next_cycle();

    // Reset cycle with requests present: nothing may leave the arbiter
    data_req_slave  = 2'b11;
    data_gnt_master = 1'b1;
    @(negedge clk);
    check_eq("rst_req_master", data_req_master, 0);
    check_eq("rst_gnt_slave", data_gnt_slave, 0);
    check_eq("rst_err", arb_err_o, 0);
    next_cycle();

    rst              = 1'b0;
    data_req_slave   = '0;
    data_gnt_master  = 1'b0;
    data_add_slave[0]   = 32'h200;
    data_wen_slave[0]   = 1'b0;
    data_wdata_slave[0] = C_WD0;
    data_be_slave[0]    = 16'h00FF;
    data_add_slave[1]   = 32'h100;
    data_wen_slave[1]   = 1'b1;
    data_be_slave[1]    = 16'hFFFF;
    @(negedge clk);
    check_eq("idle_req_master", data_req_master, 0);
    check_eq("idle_add_master", data_add_master, 0);
    next_cycle();

    // Single load from requester 1
    data_req_slave  = 2'b10;
    data_gnt_master = 1'b1;
    @(negedge clk);
    check_eq("t1_gnt_slave", data_gnt_slave, 2'b10);
    check_eq("t1_add_master", data_add_master, 32'h100);
    check_eq("t1_wen_master", data_wen_master, 1);
    check_eq("t1_be_master", data_be_master, 16'hFFFF);
    next_cycle();
    data_req_slave      = 2'b00;
    data_r_valid_master = 1'b1;
    data_r_rdata_master = C_A5;
    @(negedge clk);
    check_eq("t1_rvalid", data_r_valid_slave, 2'b10);
    check_eq("t1_rdata1", data_r_rdata_slave[1], C_A5);
    check_eq("t1_rdata0", data_r_rdata_slave[0], 0);
    next_cycle();
    data_r_valid_master = 1'b0;

    // Both requesting, grants alternate 0,1,0,1; responses follow one cycle later
    for (int k = 0; k < 5; k++) begin
      data_req_slave      = (k < 4) ? 2'b11 : 2'b00;
      data_gnt_master     = 1'b1;
      data_r_valid_master = (k > 0);
      data_r_rdata_master = 128'hC0DE_0000 + 128'(k);
      @(negedge clk);
      if (k < 4) check_eq("t2_alt_gnt", data_gnt_slave, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) begin
        check_eq("t2_rvalid", data_r_valid_slave, (k % 2 == 1) ? 2'b01 : 2'b10);
        check_eq("t2_rdata", data_r_rdata_slave[(k % 2 == 1) ? 0 : 1], 128'hC0DE_0000 + 128'(k));
        check_eq("t2_rdata_other", data_r_rdata_slave[(k % 2 == 1) ? 1 : 0], 0);
      end
      next_cycle();
    end
    data_r_valid_master = 1'b0;

    // Grant withheld for 3 cycles: winner stays requester 0
    data_req_slave  = 2'b11;
    data_gnt_master = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("t3_no_gnt", data_gnt_slave, 0);
      check_eq("t3_req_master", data_req_master, 1);
      check_eq("t3_add_w0", data_add_master, 32'h200);
      next_cycle();
    end
    data_gnt_master = 1'b1;
    @(negedge clk);
    check_eq("t3_gnt4", data_gnt_slave, 2'b01);
    check_eq("t3_wdata", data_wdata_master, C_WD0);
    check_eq("t3_be", data_be_master, 16'h00FF);
    next_cycle();
    data_req_slave      = 2'b00;
    data_r_valid_master = 1'b1;
    data_r_rdata_master = 128'h77;
    @(negedge clk);
    check_eq("t3_rvalid", data_r_valid_slave, 2'b01);
    check_eq("t3_rdata", data_r_rdata_slave[0], 128'h77);
    next_cycle();
    data_r_valid_master = 1'b0;

    // Fill the ID FIFO with responses withheld
    data_req_slave  = 2'b01;
    data_gnt_master = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("t4_fill_gnt", data_gnt_slave, 2'b01);
      next_cycle();
    end
    @(negedge clk);
    check_eq("t4_full_req", data_req_master, 0);
    check_eq("t4_full_gnt", data_gnt_slave, 0);
    next_cycle();
    data_r_valid_master = 1'b1;
    data_r_rdata_master = 128'h1;
    @(negedge clk);
    check_eq("t4_no_bypass", data_req_master, 0);
    check_eq("t4_pop_valid", data_r_valid_slave, 2'b01);
    next_cycle();
    data_r_valid_master = 1'b0;
    @(negedge clk);
    check_eq("t4_resume_req", data_req_master, 1);
    check_eq("t4_resume_gnt", data_gnt_slave, 2'b01);
    next_cycle();
    data_req_slave      = 2'b00;
    data_r_valid_master = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_r_rdata_master = 128'h10 + 128'(k);
      @(negedge clk);
      check_eq("t4_drain_valid", data_r_valid_slave, 2'b01);
      next_cycle();
    end

    // Stray response with empty FIFO
    @(negedge clk);
    check_eq("t5_stray_valid", data_r_valid_slave, 0);
    check_eq("t5_err_before", arb_err_o, 0);
    next_cycle();
    data_r_valid_master = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("t5_err_sticky", arb_err_o, 1);
      next_cycle();
    end

    // Reset with two transactions outstanding
    data_req_slave  = 2'b01;
    data_gnt_master = 1'b1;
    next_cycle();
    next_cycle();
    data_req_slave = 2'b00;
    rst            = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_req", data_req_master, 0);
    next_cycle();
    rst                 = 1'b0;
    data_r_valid_master = 1'b1;
    data_r_rdata_master = 128'hBAD;
    @(negedge clk);
    check_eq("t6_err_cleared", arb_err_o, 0);
    check_eq("t6_stray_valid", data_r_valid_slave, 0);
    next_cycle();
    data_r_valid_master = 1'b0;
    data_req_slave      = 2'b11;
    @(negedge clk);
    check_eq("t6_err_set", arb_err_o, 1);
    check_eq("t6_gnt_after_rst", data_gnt_slave, 2'b01);
    next_cycle();
    data_req_slave      = 2'b00;
    data_gnt_master     = 1'b0;
    data_r_valid_master = 1'b1;
    data_r_rdata_master = 128'h5A5A;
    @(negedge clk);
    check_eq("t6_rvalid", data_r_valid_slave, 2'b01);
    check_eq("t6_rdata", data_r_rdata_slave[0], 128'h5A5A);
    next_cycle();
    data_r_valid_master = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
